// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall encoding,
// load/store opcodes and the packed layouts of the inter-stage buses.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 148;
   localparam int MEM_TO_WB_WD = 137;
   localparam int MEM_TO_ID_WD = 104;
   localparam int STALL_BUS_WD = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;
   localparam int   STALL_MEM = 3;
   localparam int   STALL_WB  = 4;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef struct packed {
      logic [31:0] pc;
      logic        sram_en;
      logic [3:0]  sram_wen;
      logic        sel_rf_res;
      logic        hi_we;
      logic        lo_we;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [5:0]  ld_st_op;
      logic [31:0] ex_result;
      logic [31:0] hi;
      logic [31:0] lo;
   } ex_to_mem_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
   } mem_to_id_t;

   typedef struct packed {
      logic [31:0] pc;
      mem_to_id_t  wb;
   } mem_to_wb_t;

   // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] addr);
      logic res;
      res = 1'b0;
      if (op == OP_LW || op == OP_SW)
         res = (addr != 2'b00);
      else if (op == OP_LH || op == OP_LHU || op == OP_SH)
         res = addr[0];
      return res;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the MEM stage and its neighbours (EX, WB, ID, data SRAM).
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [STALL_BUS_WD-1:0] stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
   logic                    mem_excp;

   modport master (
      output stall, ex_to_mem_bus, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_id_bus, mem_excp
   );

   modport slave (
      input  stall, ex_to_mem_bus, data_sram_rdata,
      output mem_to_wb_bus, mem_to_id_bus, mem_excp
   );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load data extraction: selects byte/half/word from the read
// word by address low bits and applies sign or zero extension.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      shifted = word >> {addr, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = addr[1] ? word[31:16] : word[15:0];
      data    = word;
      case (op)
         OP_LB:   data = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  data = {24'h0, byte_v};
         OP_LH:   data = {{16{half_v[15]}}, half_v};
         OP_LHU:  data = {16'h0, half_v};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: input register, load-data buffer for stalls, load
// extraction and forwarding. Optional alignment check via MEM_ALIGN_CHK_EN.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   mem_stage_if.slave mif
);

   ex_to_mem_t  in_reg;
   logic [31:0] rdata_buf_reg;
   logic        buf_valid_reg;

   logic        in_load;
   logic        is_read;
   logic [31:0] word;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        excp;
   mem_to_id_t  id_out;
   mem_to_wb_t  wb_out;

   // The register changes (instruction or bubble) unless both MEM and WB stop.
   assign in_load = (mif.stall[STALL_MEM] == NO_STOP) || (mif.stall[STALL_WB] == NO_STOP);
   assign is_read = in_reg.sram_en && (in_reg.sram_wen == 4'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         in_reg        <= '0;
         rdata_buf_reg <= 32'h0;
         buf_valid_reg <= 1'b0;
      end else begin
         if (mif.stall[STALL_MEM] == NO_STOP)
            in_reg <= ex_to_mem_t'(mif.ex_to_mem_bus);
         else if (mif.stall[STALL_WB] == NO_STOP)
            in_reg <= '0;

         // SRAM data is only valid in the first MEM cycle; keep it for a stall.
         if (in_load) begin
            buf_valid_reg <= 1'b0;
         end else if (is_read && !buf_valid_reg) begin
            rdata_buf_reg <= mif.data_sram_rdata;
            buf_valid_reg <= 1'b1;
         end
      end
   end

   assign word = buf_valid_reg ? rdata_buf_reg : mif.data_sram_rdata;

   load_align u_load_align (
      .op   (in_reg.ld_st_op),
      .addr (in_reg.ex_result[1:0]),
      .word (word),
      .data (load_data)
   );

   assign rf_wdata = in_reg.sel_rf_res ? load_data : in_reg.ex_result;

`ifdef MEM_ALIGN_CHK_EN
   assign excp = is_misaligned(in_reg.ld_st_op, in_reg.ex_result[1:0]);
`else
   assign excp = 1'b0;
`endif

   always_comb begin
      id_out.rf_we    = in_reg.rf_we & ~excp;
      id_out.rf_waddr = in_reg.rf_waddr;
      id_out.rf_wdata = rf_wdata;
      id_out.hi_we    = in_reg.hi_we;
      id_out.lo_we    = in_reg.lo_we;
      id_out.hi       = in_reg.hi;
      id_out.lo       = in_reg.lo;
      wb_out.pc       = in_reg.pc;
      wb_out.wb       = id_out;
   end

   assign mif.mem_to_id_bus = id_out;
   assign mif.mem_to_wb_bus = wb_out;
   assign mif.mem_excp      = excp;

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage plus directed stall/bubble/reset sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

`ifdef MEM_ALIGN_CHK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_stage_if mif();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        sram_en;
      logic [3:0]  wen;
      logic        sel;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] ex_result;
      logic [31:0] rdata;
      logic [31:0] exp_wdata;
      logic        exp_rf_we;
      logic        exp_excp;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string name, input logic [5:0] op, input logic en,
                               input logic [3:0] wen, input logic sel, input logic we,
                               input logic [4:0] wa, input logic [31:0] er, input logic [31:0] rd,
                               input logic [31:0] ew, input logic ewe, input logic eex);
      vec_t v;
      v.name = name; v.op = op; v.sram_en = en; v.wen = wen; v.sel = sel; v.rf_we = we;
      v.waddr = wa; v.ex_result = er; v.rdata = rd; v.exp_wdata = ew;
      v.exp_rf_we = ewe; v.exp_excp = eex;
      return v;
   endfunction

   function automatic ex_to_mem_t mk_ex(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                        input logic sel, input logic hwe, input logic lwe,
                                        input logic we, input logic [4:0] wa, input logic [5:0] op,
                                        input logic [31:0] er, input logic [31:0] hi,
                                        input logic [31:0] lo);
      ex_to_mem_t e;
      e.pc = pc; e.sram_en = en; e.sram_wen = wen; e.sel_rf_res = sel; e.hi_we = hwe;
      e.lo_we = lwe; e.rf_we = we; e.rf_waddr = wa; e.ld_st_op = op; e.ex_result = er;
      e.hi = hi; e.lo = lo;
      return e;
   endfunction

   initial begin
      logic [31:0]  pc, hi, lo;
      logic         hwe, lwe;
      logic [103:0] exp_id;
      logic [136:0] exp_wb;
      ex_to_mem_t   e;

      vecs[0]  = mk("lb_a3",     OP_LB,  1, 4'h0, 1, 1, 5'd2,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 1, 0);
      vecs[1]  = mk("lbu_a3",    OP_LBU, 1, 4'h0, 1, 1, 5'd3,  32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 1, 0);
      vecs[2]  = mk("lhu_a2",    OP_LHU, 1, 4'h0, 1, 1, 5'd4,  32'h0000_2002, 32'h8001_0000, 32'h0000_8001, 1, 0);
      vecs[3]  = mk("lh_a2",     OP_LH,  1, 4'h0, 1, 1, 5'd6,  32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001, 1, 0);
      vecs[4]  = mk("lh_a0",     OP_LH,  1, 4'h0, 1, 1, 5'd7,  32'h0000_2000, 32'h0000_8123, 32'hFFFF_8123, 1, 0);
      vecs[5]  = mk("lb_a0",     OP_LB,  1, 4'h0, 1, 1, 5'd8,  32'h0000_3000, 32'h1234_5678, 32'h0000_0078, 1, 0);
      vecs[6]  = mk("lbu_a1",    OP_LBU, 1, 4'h0, 1, 1, 5'd9,  32'h0000_3001, 32'h1234_5678, 32'h0000_0056, 1, 0);
      vecs[7]  = mk("lb_a2_neg", OP_LB,  1, 4'h0, 1, 1, 5'd10, 32'h0000_3002, 32'h12F4_5678, 32'hFFFF_FFF4, 1, 0);
      vecs[8]  = mk("lw",        OP_LW,  1, 4'h0, 1, 1, 5'd11, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
      vecs[9]  = mk("unk_op",    6'b111111, 1, 4'h0, 1, 1, 5'd12, 32'h0000_4001, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
      vecs[10] = mk("addu",      6'b000000, 0, 4'h0, 0, 1, 5'd5,  32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 1, 0);
      vecs[11] = mk("sw",        OP_SW,  1, 4'hF, 0, 0, 5'd0,  32'h0000_2004, 32'h5555_AAAA, 32'h0000_2004, 0, 0);
      vecs[12] = mk("lw_mis",    OP_LW,  1, 4'h0, 1, 1, 5'd13, 32'h0000_1002, 32'h1122_3344, 32'h1122_3344,
                    !ALIGN_CHK, ALIGN_CHK);

      // Reset overrides a stall with a live instruction on the input bus.
      mif.stall           = 6'b011000;
      mif.data_sram_rdata = 32'hFFFF_FFFF;
      mif.ex_to_mem_bus   = mk_ex(32'h1234_5678, 1, 4'h0, 1, 1, 1, 1, 5'd31, OP_LW, 32'h10, 32'h1, 32'h2);
      tick();
      tick();
      check("rst_wb",   mif.mem_to_wb_bus, '0);
      check("rst_id",   mif.mem_to_id_bus, '0);
      check("rst_excp", mif.mem_excp, '0);
      rst        = 1'b0;
      mif.stall  = 6'b000000;

      for (int i = 0; i < NV; i++) begin
         pc  = 32'h0040_0000 + 32'(i * 4);
         hi  = 32'hA000_0000 + 32'(i);
         lo  = 32'h5000_0000 + 32'(i);
         hwe = i[0];
         lwe = i[1];
         mif.ex_to_mem_bus = mk_ex(pc, vecs[i].sram_en, vecs[i].wen, vecs[i].sel, hwe, lwe,
                                   vecs[i].rf_we, vecs[i].waddr, vecs[i].op, vecs[i].ex_result, hi, lo);
         mif.data_sram_rdata = 32'h0BAD_0BAD;
         tick();
         mif.data_sram_rdata = vecs[i].rdata;
         #1;
         exp_id = {vecs[i].exp_rf_we, vecs[i].waddr, vecs[i].exp_wdata, hwe, lwe, hi, lo};
         exp_wb = {pc, exp_id};
         check({vecs[i].name, "_wb"},   mif.mem_to_wb_bus, exp_wb);
         check({vecs[i].name, "_id"},   mif.mem_to_id_bus, {33'h0, exp_id});
         check({vecs[i].name, "_excp"}, mif.mem_excp, {136'h0, vecs[i].exp_excp});
      end

      // lw held by a stall while the SRAM output moves on: buffered word persists.
      mif.ex_to_mem_bus = mk_ex(32'h0040_1000, 1, 4'h0, 1, 0, 0, 1, 5'd14, OP_LW, 32'h0000_8000, 32'h0, 32'h0);
      tick();
      mif.data_sram_rdata = 32'hDEAD_BEEF;
      mif.stall = 6'b011000;
      mif.ex_to_mem_bus = mk_ex(32'h0040_2000, 0, 4'h0, 0, 0, 0, 1, 5'd1, 6'h0, 32'h1111_1111, 32'h0, 32'h0);
      #1;
      check("hold_c0", mif.mem_to_id_bus, {33'h0, 1'b1, 5'd14, 32'hDEAD_BEEF, 66'h0});
      tick();
      mif.data_sram_rdata = 32'h0000_0000;
      for (int c = 1; c <= 3; c++) begin
         #1;
         check($sformatf("hold_c%0d", c), mif.mem_to_wb_bus,
               {32'h0040_1000, 1'b1, 5'd14, 32'hDEAD_BEEF, 66'h0});
         tick();
      end

      // Bubble: MEM stops, WB runs -> outputs clear; then a new instruction flows.
      mif.stall = 6'b001000;
      tick();
      check("bubble_wb", mif.mem_to_wb_bus, '0);
      check("bubble_id", mif.mem_to_id_bus, '0);
      mif.stall = 6'b000000;
      mif.ex_to_mem_bus = mk_ex(32'h0040_3000, 0, 4'h0, 0, 0, 0, 1, 5'd5, 6'h0, 32'h0000_0007, 32'h0, 32'h0);
      tick();
      check("after_bubble", mif.mem_to_wb_bus, {32'h0040_3000, 1'b1, 5'd5, 32'h0000_0007, 66'h0});

      // Reset during a held lw discards both the instruction and the buffer.
      mif.ex_to_mem_bus = mk_ex(32'h0040_4000, 1, 4'h0, 1, 0, 0, 1, 5'd20, OP_LW, 32'h0000_9000, 32'h0, 32'h0);
      tick();
      mif.data_sram_rdata = 32'h1357_2468;
      mif.stall = 6'b011000;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_hold_wb",  mif.mem_to_wb_bus, '0);
      check("rst_hold_id",  mif.mem_to_id_bus, '0);
      check("rst_hold_buf", dut.buf_valid_reg, '0);
      tick();
      check("rst_hold_stay", mif.mem_to_wb_bus, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
